// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: stalls the datapath, runs one word-aligned bus access, returns extended load data.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses raise err instead of being force-aligned.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        FIN
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic              done_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [3:0]        bus_be_q;
    logic [31:0]       bus_wdata_q;

    logic              illegal_d;
    logic [1:0]        off_d;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       shifted_d;
    logic [31:0]       load_d;

    // Request decode: legality, effective byte offset, lanes
    always_comb begin
        illegal_d = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                    (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
        off_d     = req_addr[1:0];
`ifdef MISALIGN_TRAP_EN
        if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
            (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)) begin
            illegal_d = 1'b1;
        end
`else
        if (req_funct3[1:0] == 2'b01) begin
            off_d = {req_addr[1], 1'b0};
        end else if (req_funct3[1:0] == 2'b10) begin
            off_d = 2'b00;
        end
`endif
        addr_d = {req_addr[ADDR_W-1:2], 2'b00};
        case (req_funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << off_d;
                wdata_d = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << off_d;
                wdata_d = {2{req_wdata[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = req_wdata;
            end
        endcase
    end

    // Load extraction from the raw bus word using the captured offset and funct3
    always_comb begin
        shifted_d = bus_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
            3'b100:  load_d = {24'h000000, shifted_d[7:0]};
            3'b001:  load_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
            3'b101:  load_d = {16'h0000, shifted_d[15:0]};
            default: load_d = shifted_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q <= req_funct3;
                        off_q    <= off_d;
                        cnt_q    <= '0;
                        if (illegal_d) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= BUS;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= req_we;
                            bus_addr_q  <= addr_d;
                            bus_be_q    <= be_d;
                            bus_wdata_q <= wdata_d;
                        end
                    end
                end
                BUS: begin
                    // Ack is checked before the timeout so a last-cycle ack still succeeds
                    if (bus_ack) begin
                        state_q   <= FIN;
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        if (!bus_we_q) begin
                            rdata_q <= load_d;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        state_q   <= FIN;
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall     = ((state_q == IDLE) && req_valid) || (state_q == BUS);
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl (TIMEOUT_CYC=4); honours MISALIGN_TRAP_EN when defined.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    mem_access_ctrl #(
        .ADDR_W      (32),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          cycles;
    } bus_exp_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          stall;
    } resp_exp_t;

    bus_exp_t  exp_bus_q[$];
    resp_exp_t exp_resp_q[$];

    int checks = 0;
    int errors = 0;

    int          ack_delay = -1;
    logic [31:0] ack_data  = '0;
    logic        stray_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Bus responder: acks after ack_delay cycles of bus_req (negative = never)
    initial begin
        int rsp_cnt;
        rsp_cnt   = 0;
        bus_ack   = 1'b0;
        bus_rdata = 32'hBAD0BAD0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req && ack_delay >= 0 && rsp_cnt == ack_delay) begin
                bus_ack   = 1'b1;
                bus_rdata = ack_data;
            end else begin
                bus_ack   = stray_ack;
                bus_rdata = stray_ack ? ack_data : 32'hBAD0BAD0;
            end
            rsp_cnt = bus_req ? rsp_cnt + 1 : 0;
        end
    end

    // Monitor: bus fields on bus_req rise, bus_req length on fall, response on done
    logic prev_breq = 1'b0;
    int   breq_cnt  = 0;
    int   stall_cnt = 0;
    always @(negedge clk) begin
        bus_exp_t  b;
        resp_exp_t r;
        if (rst_n !== 1'b1) stall_cnt = 0;
        else if (stall === 1'b1) stall_cnt++;

        if (bus_req === 1'b1) begin
            if (!prev_breq) begin
                breq_cnt = 0;
                if (exp_bus_q.size() == 0) begin
                    fail_evt("unexpected_bus_req");
                end else begin
                    b = exp_bus_q[0];
                    chk("bus_addr", bus_addr, b.addr);
                    chk("bus_be", {28'h0, bus_be}, {28'h0, b.be});
                    chk("bus_we", {31'h0, bus_we}, {31'h0, b.we});
                    if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
                end
            end
            breq_cnt++;
        end else if (prev_breq) begin
            if (exp_bus_q.size() != 0) begin
                b = exp_bus_q.pop_front();
                chk("bus_req_cycles", breq_cnt, b.cycles);
            end
        end
        prev_breq = (bus_req === 1'b1);

        if (done === 1'b1) begin
            if (exp_resp_q.size() == 0) begin
                fail_evt("unexpected_done");
            end else begin
                r = exp_resp_q.pop_front();
                chk("err", {31'h0, err}, {31'h0, r.err});
                chk("rdata", rdata, r.rdata);
                chk("stall_cycles", stall_cnt, r.stall);
            end
            stall_cnt = 0;
        end else if (err === 1'b1) begin
            fail_evt("err_without_done");
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay, input logic [31:0] brd,
                         input logic has_bus, input logic [31:0] eaddr, input logic [3:0] ebe,
                         input logic [31:0] ewdata, input logic eerr, input logic [31:0] erdata);
        bus_exp_t  b;
        resp_exp_t r;
        int        n;
        b.addr   = eaddr;
        b.be     = ebe;
        b.we     = we;
        b.wdata  = ewdata;
        b.cycles = (delay < 0) ? 4 : delay + 1;
        r.err    = eerr;
        r.rdata  = erdata;
        r.stall  = has_bus ? b.cycles + 1 : 1;
        if (has_bus) exp_bus_q.push_back(b);
        exp_resp_q.push_back(r);
        ack_delay = delay;
        ack_data  = brd;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) fail_evt("done_wait_timeout");
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
        chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", {28'h0, bus_be}, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //    we    f3      addr          wdata         dly brd           bus   eaddr         ebe      ewdata        eerr  erdata
        issue(1'b0, 3'b010, 32'h00000100, 32'h0,        0,  32'hDEADBEEF, 1'b1, 32'h00000100, 4'b1111, 32'h0,        1'b0, 32'hDEADBEEF);
        issue(1'b0, 3'b000, 32'h00000103, 32'h0,        1,  32'h80112233, 1'b1, 32'h00000100, 4'b1000, 32'h0,        1'b0, 32'hFFFFFF80);
        issue(1'b0, 3'b100, 32'h00000103, 32'h0,        0,  32'h80112233, 1'b1, 32'h00000100, 4'b1000, 32'h0,        1'b0, 32'h00000080);
        issue(1'b1, 3'b001, 32'h00000022, 32'h0000ABCD, 0,  32'h0,        1'b1, 32'h00000020, 4'b1100, 32'hABCDABCD, 1'b0, 32'h00000080);
        issue(1'b0, 3'b001, 32'h00000102, 32'h0,        0,  32'h80011234, 1'b1, 32'h00000100, 4'b1100, 32'h0,        1'b0, 32'hFFFF8001);
        issue(1'b0, 3'b101, 32'h00000100, 32'h0,        2,  32'h80011234, 1'b1, 32'h00000100, 4'b0011, 32'h0,        1'b0, 32'h00001234);
        issue(1'b1, 3'b000, 32'h00000201, 32'h123456A5, 0,  32'h0,        1'b1, 32'h00000200, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h00001234);
        // ack lands in the last allowed cycle: success
        issue(1'b1, 3'b010, 32'h00000300, 32'hCAFEF00D, 3,  32'h0,        1'b1, 32'h00000300, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h00001234);
        // no ack: timeout after 4 bus cycles
        issue(1'b0, 3'b010, 32'h00000400, 32'h0,        -1, 32'h0,        1'b1, 32'h00000400, 4'b1111, 32'h0,        1'b1, 32'h00001234);
        // illegal encodings: no bus access
        issue(1'b0, 3'b011, 32'h00000500, 32'h0,        0,  32'h55555555, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h00001234);
        issue(1'b1, 3'b100, 32'h00000500, 32'h0,        0,  32'h55555555, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h00001234);
        issue(1'b0, 3'b110, 32'h00000500, 32'h0,        0,  32'h55555555, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h00001234);
`ifdef MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 32'h00000102, 32'h0,        0,  32'h11223344, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h00001234);
        issue(1'b0, 3'b001, 32'h00000103, 32'h0,        0,  32'hAABBCCDD, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h00001234);
`else
        issue(1'b0, 3'b010, 32'h00000102, 32'h0,        0,  32'h11223344, 1'b1, 32'h00000100, 4'b1111, 32'h0,        1'b0, 32'h11223344);
        issue(1'b0, 3'b001, 32'h00000103, 32'h0,        0,  32'hAABBCCDD, 1'b1, 32'h00000100, 4'b1100, 32'h0,        1'b0, 32'hFFFFAABB);
`endif

        // stray ack while idle must not start or complete anything
        ack_data = 32'h77777777;
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stray_ack_bus_req", {31'h0, bus_req}, 32'h0);
        chk("stray_ack_stall", {31'h0, stall}, 32'h0);

        // reset in the middle of a bus access, then a late ack
        begin
            bus_exp_t b;
            b.addr   = 32'h00000600;
            b.be     = 4'b1111;
            b.we     = 1'b0;
            b.wdata  = '0;
            b.cycles = 2;
            exp_bus_q.push_back(b);
        end
        ack_delay = -1;
        ack_data  = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h00000600;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_drops_bus_req", {31'h0, bus_req}, 32'h0);
        chk("reset_drops_stall", {31'h0, stall}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("late_ack_rdata", rdata, 32'h0);
        chk("late_ack_bus_req", {31'h0, bus_req}, 32'h0);

        chk("bus_queue_drained", exp_bus_q.size(), 32'd0);
        chk("resp_queue_drained", exp_resp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Multi-cycle load/store sequencer between the single-cycle datapath and a handshaked data-memory bus. It is triggered when the control word marks a memory instruction. It stalls the datapath through clk_en, drives one word-aligned bus transaction with byte enables, and returns aligned, sign- or zero-extended load data. It also reports a bus timeout or an illegal access.

Parameters:
ADDR_W, 32, byte address width of req_addr and bus_addr
TIMEOUT_CYC, 255, maximum cycles spent waiting for bus_ack before the access is aborted (1..255)

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  datapath requests a memory op this cycle (level; held while stall=1)
req_we  in  1  1=store, 0=load (from MemRW)
req_funct3  in  3  inst_14_12: size and sign
req_addr  in  ADDR_W  byte address from the ALU
req_wdata  in  32  store data (rs2)
stall  out  1  1=datapath must hold; drives clk_en low
done  out  1  one-cycle pulse when the access completes
err  out  1  one-cycle pulse, coincident with done, on timeout or illegal access
rdata  out  32  aligned and extended load result; held between loads
bus_req  out  1  bus request
bus_we  out  1  bus write
bus_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  bus completion; bus_rdata valid in the same cycle
bus_rdata  in  32  raw read word

Behaviour:
Interface:
- One clock, clk. Reset rst_n is synchronous and active-low.
- Reset puts the FSM in IDLE, clears the timeout counter, and drives every output to 0 (stall, done, err, rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata).

FSM states: IDLE, BUS, FIN.
- stall = (state==IDLE && req_valid) || state==BUS. It is 0 in FIN.
- IDLE: when req_valid=1, capture we/funct3/addr/wdata.
  - If the access is illegal, go to FIN with err pending.
  - Otherwise go to BUS, with bus_req and all bus fields registered.
- BUS:
  - bus_req and bus_we/addr/be/wdata stay constant until bus_ack is sampled 1.
  - On ack: go to FIN. For a load, register rdata from bus_rdata. For a store, rdata is unchanged.
  - bus_req drops in the cycle after ack.
  - The timeout counter increments each BUS cycle. On reaching TIMEOUT_CYC without ack: drop bus_req, go to FIN with err, leave rdata unchanged.
- FIN: done=1 for one cycle, err as pending. Then go to IDLE unconditionally. A req_valid seen in FIN is ignored; the datapath re-presents it in IDLE.
- Minimum latency: request in cycle 0, bus_req in cycle 1, ack in cycle 1, done in cycle 2. Stall is high in cycles 0-1.

Legality:
- funct3 in {011, 110, 111} is illegal: err, no bus access.
- For a store, funct3 bit 2 set is illegal.

Lanes:
- bus_be:
  - byte: 0001 << addr[1:0]
  - half: 0011 << {addr[1],1'b0}
  - word: 1111
- bus_wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata

Load extraction:
- Shift bus_rdata right by 8*addr[1:0].
- Then extend by funct3:
  - 000: sign-extend 8 bits
  - 100: zero-extend 8 bits
  - 001: sign-extend 16 bits
  - 101: zero-extend 16 bits
  - 010: whole word

Boundary conditions:
- bus_ack while bus_req=0 is ignored.
- An ack in the same cycle the timeout is reached counts as success.
- Reset mid-BUS abandons the transaction. bus_req drops on the reset edge, and a late ack is ignored.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is illegal. Result: err+done in FIN, no bus access, rdata unchanged.
- Undefined: misaligned addresses are silently forced to natural alignment (half: addr[0]=0; word: addr[1:0]=0). The access proceeds normally with no err.

Test Plan:
- LW addr=0x100, ack 1 cycle after bus_req with bus_rdata=0xDEADBEEF -> bus_addr=0x100, be=1111, done in cycle 2, rdata=0xDEADBEEF, stall high for 2 cycles.
- LB addr=0x103, bus_rdata=0x80112233 -> be=1000, rdata=0xFFFFFF80. Same access as LBU -> rdata=0x00000080.
- SH addr=0x22, wdata=0x0000ABCD -> bus_addr=0x20, be=1100, bus_wdata=0xABCDABCD, bus_we=1, rdata unchanged.
- No ack, TIMEOUT_CYC=4 -> bus_req high for exactly 4 cycles, then done=1 and err=1 together, stall released.
- rst_n=0 while in BUS, then ack arrives 2 cycles after release -> bus_req 0 from the reset edge, no done/err pulse, rdata=0.
- LW addr=0x102 -> with MISALIGN_TRAP_EN: err+done and no bus_req. Without it: bus_addr=0x100, normal completion.
